dma_multi_ch_sched: RTL

Multi-channel chunk scheduler for the next-generation DMA datapath; it sits between the CSR descriptor bank and the shared read/write streamer pair. It generalises the single-FSM, fixed-descriptor control path to `NUM_CH` independent channels. Per channel it splits each transfer into AXI-legal chunks, capped by max burst and by 4 KB boundaries on both source and destination. It arbitrates channels round-robin, keeps one chunk in flight, and tracks per-channel progress, done, error and abort.

---
 rtl/dma_multi_ch_sched.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/dma_multi_ch_sched.sv
// Multi-channel DMA chunk scheduler: splits per-channel transfers into burst/4 KB-legal chunks
// and issues them round-robin, one in flight. Define DMA_CH_PRIO_EN for a high-priority class.
module dma_multi_ch_sched #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 32,
    localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_go_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_src_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_dst_i,
    input  logic [NUM_CH*LEN_W-1:0]    ch_len_i,
    input  logic [NUM_CH-1:0]          ch_prio_i,
    input  logic                       abort_i,
    input  logic [7:0]                 max_burst_i,
    output logic                       chk_valid_o,
    input  logic                       chk_ready_i,
    output logic [CH_W-1:0]            chk_ch_o,
    output logic [ADDR_W-1:0]          chk_src_o,
    output logic [ADDR_W-1:0]          chk_dst_o,
    output logic [12:0]                chk_bytes_o,
    input  logic                       chk_done_i,
    input  logic                       chk_err_i,
    output logic [NUM_CH-1:0]          ch_busy_o,
    output logic [NUM_CH-1:0]          ch_done_o,
    output logic [NUM_CH-1:0]          ch_err_o,
    output logic                       active_o
);
    localparam int unsigned BPB = DATA_W / 8;
    localparam int unsigned CW  = (LEN_W > 16) ? LEN_W : 16;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BPB - 1);

    typedef enum logic [1:0] {StIdle, StArb, StIssue, StWait} state_e;

    state_e             state_q, state_d;
    logic [NUM_CH-1:0]  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0]  src_q [NUM_CH];
    logic [ADDR_W-1:0]  src_d [NUM_CH];
    logic [ADDR_W-1:0]  dst_q [NUM_CH];
    logic [ADDR_W-1:0]  dst_d [NUM_CH];
    logic [LEN_W-1:0]   rem_q [NUM_CH];
    logic [LEN_W-1:0]   rem_d [NUM_CH];
    logic [CH_W-1:0]    ptr_q, ptr_d, cur_q, cur_d;
    logic [ADDR_W-1:0]  csrc_q, csrc_d, cdst_q, cdst_d;
    logic [12:0]        cbytes_q, cbytes_d;
    logic               discard_q, discard_d;
    logic               wait_exit;

    logic [NUM_CH-1:0]  cand;
    logic [CH_W:0]      pick;
    logic [CH_W-1:0]    gnt;
    logic [CW-1:0]      rem_c, burst_c, src_room, dst_room, size_c;

    // Returns {found, index} of the first set bit after 'last', wrapping.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] mask,
                                              input logic [CH_W-1:0]   last);
        logic [CH_W:0] res;
        int            idx;
        res = '0;
        for (int i = int'(NUM_CH); i > 0; i--) begin
            idx = (int'(last) + i) % int'(NUM_CH);
            if (mask[idx]) res = {1'b1, idx[CH_W-1:0]};
        end
        return res;
    endfunction

`ifdef DMA_CH_PRIO_EN
    logic [NUM_CH-1:0] hi_busy;
    assign hi_busy = busy_q & ch_prio_i;
    assign cand    = (hi_busy != '0) ? hi_busy : busy_q;
`else
    logic unused_prio;
    assign unused_prio = ^ch_prio_i;
    assign cand        = busy_q;
`endif

    always_comb begin
        pick     = rr_pick(cand, ptr_q);
        gnt      = pick[CH_W-1:0];
        rem_c    = CW'(rem_q[gnt]);
        burst_c  = (CW'(max_burst_i) + CW'(1)) * CW'(BPB);
        src_room = CW'(13'd4096 - {1'b0, src_q[gnt][11:0]});
        dst_room = CW'(13'd4096 - {1'b0, dst_q[gnt][11:0]});
        size_c   = rem_c;
        if (burst_c < size_c)  size_c = burst_c;
        if (src_room < size_c) size_c = src_room;
        if (dst_room < size_c) size_c = dst_room;
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        csrc_d    = csrc_q;
        cdst_d    = cdst_q;
        cbytes_d  = cbytes_q;
        discard_d = discard_q;
        wait_exit = 1'b0;

        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (ch_go_i[c] && !busy_q[c] && !abort_i) begin
                src_d[c]  = ch_src_i[c*ADDR_W +: ADDR_W];
                dst_d[c]  = ch_dst_i[c*ADDR_W +: ADDR_W];
                rem_d[c]  = ch_len_i[c*LEN_W +: LEN_W];
                done_d[c] = 1'b0;
                err_d[c]  = 1'b0;
                if (ch_len_i[c*LEN_W +: LEN_W] == '0) begin
                    done_d[c] = 1'b1;
                end else if (((ch_src_i[c*ADDR_W +: ADDR_W] |
                               ch_dst_i[c*ADDR_W +: ADDR_W]) & ALIGN_MASK) != '0) begin
                    err_d[c] = 1'b1;
                end else begin
                    busy_d[c] = 1'b1;
                end
            end
        end

        unique case (state_q)
            StIdle: if (busy_q != '0 && !abort_i) state_d = StArb;
            StArb: begin
                if (abort_i || !pick[CH_W]) begin
                    state_d = StIdle;
                end else begin
                    ptr_d    = gnt;
                    cur_d    = gnt;
                    csrc_d   = src_q[gnt];
                    cdst_d   = dst_q[gnt];
                    cbytes_d = 13'(size_c);
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                // An accepted chunk must still be drained, so abort on the same cycle as
                // ready waits for its completion and drops the result.
                if (chk_ready_i) begin
                    state_d   = StWait;
                    discard_d = abort_i;
                end else if (abort_i) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (abort_i) discard_d = 1'b1;
                if (chk_done_i) begin
                    wait_exit = 1'b1;
                    discard_d = 1'b0;
                    if (!discard_q && !abort_i) begin
                        if (chk_err_i) begin
                            busy_d[cur_q] = 1'b0;
                            err_d[cur_q]  = 1'b1;
                        end else begin
                            src_d[cur_q] = src_q[cur_q] + ADDR_W'(cbytes_q);
                            dst_d[cur_q] = dst_q[cur_q] + ADDR_W'(cbytes_q);
                            rem_d[cur_q] = rem_q[cur_q] - LEN_W'(cbytes_q);
                            if (rem_q[cur_q] == LEN_W'(cbytes_q)) begin
                                busy_d[cur_q] = 1'b0;
                                done_d[cur_q] = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort_i) busy_d = '0;
        if (wait_exit) begin
            state_d = (discard_q || abort_i || busy_d == '0) ? StIdle : StArb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            busy_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
            ptr_q     <= CH_W'(NUM_CH - 1);
            cur_q     <= '0;
            csrc_q    <= '0;
            cdst_q    <= '0;
            cbytes_q  <= '0;
            discard_q <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                src_q[c] <= '0;
                dst_q[c] <= '0;
                rem_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            csrc_q    <= csrc_d;
            cdst_q    <= cdst_d;
            cbytes_q  <= cbytes_d;
            discard_q <= discard_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
        end
    end

    assign chk_valid_o = (state_q == StIssue);
    assign chk_ch_o    = cur_q;
    assign chk_src_o   = csrc_q;
    assign chk_dst_o   = cdst_q;
    assign chk_bytes_o = cbytes_q;
    assign ch_busy_o   = busy_q;
    assign ch_done_o   = done_q;
    assign ch_err_o    = err_q;
    assign active_o    = (busy_q != '0) || (state_q != StIdle);

endmodule
